// File: rtl/pc_sequencer.sv
// pc_sequencer
// ------------
// Fetch/execute controller that owns the program counter. It issues
// instruction-fetch requests with a req/ack handshake. It presents the
// fall-through PC (pc + 1) to the branch unit and commits the branch unit's
// next-PC once per retired instruction. It also handles start, stall and
// halt.
//
// Optional feature: define BRANCH_STATS_EN to count taken branches on
// branch_count. Without the macro, branch_count is tied to zero and no
// counter register exists.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous active-high reset
//   start        begin execution at START_PC (honoured in IDLE/HALTED only)
//   fetch_ack    instruction memory has the instruction for pc (FETCH only)
//   stall        hold the current instruction in EXEC
//   halt         decoded instruction is halt (sampled in EXEC)
//   pc_next      next-PC result from the branch unit
//   pc           current program counter / fetch address
//   pc_inc       pc + 1 mod 2^D, fall-through PC for the branch unit
//   fetch_req    fetch request, high throughout FETCH
//   instr_valid  instruction valid, high throughout EXEC
//   branch_taken EXEC and pc_next != pc_inc (combinational)
//   done         program halted, high throughout HALTED
//   retired      retired-instruction counter (wraps)
//   branch_count taken-branch counter (wraps), zero unless BRANCH_STATS_EN

module pc_sequencer #(
    parameter int             D        = 12,
    parameter logic [D-1:0]   START_PC = '0,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fetch_ack,
    input  logic             stall,
    input  logic             halt,
    input  logic [D-1:0]     pc_next,
    output logic [D-1:0]     pc,
    output logic [D-1:0]     pc_inc,
    output logic             fetch_req,
    output logic             instr_valid,
    output logic             branch_taken,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] branch_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t           state_q;
    logic [D-1:0]     pc_q;
    logic             fetch_req_q;
    logic             instr_valid_q;
    logic             done_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic             start_ok_s;
    logic             commit_s;

    // Fall-through PC and retired+1 wrap naturally by truncation.
    assign pc_inc    = pc_q + {{(D-1){1'b0}}, 1'b1};
    assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};

    assign start_ok_s   = start && ((state_q == S_IDLE) || (state_q == S_HALTED));
    // A non-halt retirement: this is where pc_next is committed.
    assign commit_s     = (state_q == S_EXEC) && !stall && !halt;
    assign branch_taken = (state_q == S_EXEC) && (pc_next != pc_inc);

    assign pc          = pc_q;
    assign fetch_req   = fetch_req_q;
    assign instr_valid = instr_valid_q;
    assign done        = done_q;
    assign retired     = retired_q;

    // Sequencer FSM with registered strobes, pc and retired counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            retired_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_q     <= S_FETCH;
                        pc_q        <= START_PC;
                        fetch_req_q <= 1'b1;
                        done_q      <= 1'b0;
                        retired_q   <= '0;
                    end
                end
                S_FETCH: begin
                    if (fetch_ack) begin
                        state_q       <= S_EXEC;
                        fetch_req_q   <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // Stall wins over halt; nothing moves while stalled.
                    if (!stall) begin
                        retired_q     <= retired_d;
                        instr_valid_q <= 1'b0;
                        if (halt) begin
                            state_q <= S_HALTED;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_FETCH;
                            pc_q        <= pc_next;
                            fetch_req_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    pc_q          <= '0;
                    fetch_req_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                    done_q        <= 1'b0;
                    retired_q     <= '0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] branch_count_q;
    logic [CNT_W-1:0] branch_count_d;

    assign branch_count_d = branch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign branch_count   = branch_count_q;

    // Taken-branch counter: cleared on start, bumped on taken retirements.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_q <= '0;
        end else if (start_ok_s) begin
            branch_count_q <= '0;
        end else if (commit_s && branch_taken) begin
            branch_count_q <= branch_count_d;
        end else begin
            branch_count_q <= branch_count_q;
        end
    end
`else
    assign branch_count = '0;
    // start_ok_s and commit_s only feed the optional counter.
    logic unused_s;
    assign unused_s = start_ok_s ^ commit_s;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized stimulus. Every output is compared each cycle against a
// behavioural model of the program's progress (mode, pc, counters).
module tb_pc_sequencer;

    localparam int           D        = 12;
    localparam logic [D-1:0] START_PC = 12'h000;
    localparam int           CNT_W    = 8;

    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

    logic             clk = 1'b0;
    logic             reset, start, fetch_ack, stall, halt;
    logic [D-1:0]     pc_next;
    logic [D-1:0]     pc, pc_inc;
    logic             fetch_req, instr_valid, branch_taken, done;
    logic [CNT_W-1:0] retired, branch_count;

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_mode;
    int m_pc;
    int m_ret;
    int m_bc;

    pc_sequencer #(.D(D), .START_PC(START_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .fetch_ack(fetch_ack),
        .stall(stall), .halt(halt), .pc_next(pc_next), .pc(pc),
        .pc_inc(pc_inc), .fetch_req(fetch_req), .instr_valid(instr_valid),
        .branch_taken(branch_taken), .done(done), .retired(retired),
        .branch_count(branch_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int fall();
        return (m_pc + 1) % (1 << D);
    endfunction

    // One clock: drive inputs, compare outputs against the model, advance.
    task automatic cycle(input logic rst, input logic st, input logic ack,
                         input logic stl, input logic hlt, input int pn);
        int exp_bc;
        reset = rst; start = st; fetch_ack = ack; stall = stl; halt = hlt;
        pc_next = pn[D-1:0];
        #1;
`ifdef BRANCH_STATS_EN
        exp_bc = m_bc;
`else
        exp_bc = 0;
`endif
        check_eq("pc",           32'(pc),           32'(m_pc));
        check_eq("pc_inc",       32'(pc_inc),       32'(fall()));
        check_eq("fetch_req",    32'(fetch_req),    32'(m_mode == M_FETCH));
        check_eq("instr_valid",  32'(instr_valid),  32'(m_mode == M_EXEC));
        check_eq("done",         32'(done),         32'(m_mode == M_HALT));
        check_eq("branch_taken", 32'(branch_taken), 32'((m_mode == M_EXEC) && (pn != fall())));
        check_eq("retired",      32'(retired),      32'(m_ret));
        check_eq("branch_count", 32'(branch_count), 32'(exp_bc));
        @(posedge clk);
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_ret = 0; m_bc = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALT: if (st) begin
                    m_mode = M_FETCH; m_pc = int'(START_PC); m_ret = 0; m_bc = 0;
                end
                M_FETCH: if (ack) m_mode = M_EXEC;
                M_EXEC: if (!stl) begin
                    m_ret = (m_ret + 1) % (1 << CNT_W);
                    if (hlt) begin
                        m_mode = M_HALT;
                    end else begin
                        if (pn != fall()) m_bc = (m_bc + 1) % (1 << CNT_W);
                        m_pc   = pn;
                        m_mode = M_FETCH;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        @(negedge clk);
    endtask

    // Run straight-line instructions until the model reaches EXEC at target_pc.
    task automatic run_to_exec(input int target_pc);
        int n;
        n = 0;
        while (!(m_mode == M_EXEC && m_pc == target_pc) && n < 200) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fall());
            n++;
        end
        check_eq("reach_exec_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int pn;
        reset = 1'b1; start = 1'b0; fetch_ack = 1'b0; stall = 1'b0;
        halt = 1'b0; pc_next = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_mode = M_IDLE; m_pc = 0; m_ret = 0; m_bc = 0;

        // Idle with strobes ignored, then start and straight-line execution.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fall());
        check_eq("pc_after_3", 32'(pc), 32'd3);
        check_eq("retired_3", 32'(retired), 32'd3);

        // Absolute jump from pc=5 to 0x040.
        run_to_exec(5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h040);
        check_eq("jump_pc", 32'(pc), 32'h040);

        // Delayed ack: four cycles without, then ack.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fall());

        // Stall with halt for 3 cycles, then halt.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h123);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123);
        check_eq("halted_done", 32'(done), 32'd1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_eq("restart_retired", 32'(retired), 32'd0);

        // pc wrap at 0xFFF.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fall());

        // Retired counter wrap (2^CNT_W retirements).
        for (int i = 0; i < 2 * (1 << CNT_W) + 4; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fall());

        // Reset during FETCH with ack in the same cycle.
        if (m_mode != M_FETCH) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fall());
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        check_eq("reset_abort_pc", 32'(pc), 32'd0);

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            pn = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (1 << D) - 1)) : fall();
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, pn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
